chess_scan_seq: RTL and testbench

Host-side initiator for the chess move-generator command bus. Loads pieces into the generator and runs a full MVV-LVA scan for one side: issues FIND-VICTIM / FIND-AGGRESSOR / enable-mask commands, samples the 8-bit response, and streams pseudo-legal (from, to) pairs through a valid/ready port. It sits between the system controller and the generator's ui_in / uio_in / uo_out pins.

---
 rtl/chess_scan_seq_if.sv | 28 ++
 rtl/chess_scan_seq.sv | 187 ++++++++++++++++++
 tb/tb_chess_scan_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chess_scan_seq_if.sv
// Bus bundle between the scan sequencer and its neighbours: piece loading,
// the move-generator command/response pins and the outgoing move stream.
interface chess_scan_seq_if;
    // Handshakes (load_valid/load_ready, move_valid/move_ready): a transfer happens on a
    // rising clk edge where valid and ready are both high; once raised, valid and its
    // payload stay stable until that edge; ready may depend on state but never on valid.
    logic       load_valid;
    logic       load_ready;
    logic [5:0] load_sq;
    logic [3:0] load_piece;
    logic [7:0] cmd_addr;
    logic [5:0] cmd_data;
    logic [7:0] resp;
    logic       move_valid;
    logic       move_ready;
    logic [5:0] move_from;
    logic [5:0] move_to;

    modport master (
        input  load_valid, load_sq, load_piece, resp, move_ready,
        output load_ready, cmd_addr, cmd_data, move_valid, move_from, move_to
    );

    modport slave (
        output load_valid, load_sq, load_piece, resp, move_ready,
        input  load_ready, cmd_addr, cmd_data, move_valid, move_from, move_to
    );
endinterface

// File: rtl/chess_scan_seq.sv
// Host-side initiator for the chess move generator: loads pieces and walks an
// MVV-LVA capture scan, streaming pseudo-legal (from, to) pairs out.
module chess_scan_seq #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    chess_scan_seq_if.master   bus,
    input  logic               start,
    input  logic               start_wtm,
    output logic               busy,
    output logic               done,
    output logic               illegal_pos,
    output logic [COUNT_W-1:0] move_count,
    output logic [3:0]         dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_EN_ALL  = 4'd2,
        S_VFIND   = 4'd3,
        S_VWAIT   = 4'd4,
        S_AFIND   = 4'd5,
        S_AWAIT   = 4'd6,
        S_EMIT    = 4'd7,
        S_ADIS    = 4'd8,
        S_RECOLOR = 4'd9,
        S_VDIS    = 4'd10,
        S_DONE    = 4'd11
    } state_t;

    state_t             state_q, state_d;
    logic               wtm_q, wtm_d;
    logic               first_q, first_d;
    logic [5:0]         victim_q, victim_d;
    logic [5:0]         aggr_q, aggr_d;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [7:0]         cmd_addr_q, cmd_addr_d;
    logic [5:0]         cmd_data_q, cmd_data_d;
    logic [7:0]         shadow_addr_q, shadow_addr_d;
    logic [5:0]         shadow_data_q, shadow_data_d;

    always_comb begin
        state_d       = state_q;
        wtm_d         = wtm_q;
        first_d       = first_q;
        victim_d      = victim_q;
        aggr_d        = aggr_q;
        illegal_d     = illegal_q;
        count_d       = count_q;
        shadow_addr_d = shadow_addr_q;
        shadow_data_d = shadow_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.load_valid) begin
                    state_d = S_LOAD;
                end else if (start) begin
                    state_d   = S_EN_ALL;
                    wtm_d     = start_wtm;
                    first_d   = 1'b1;
                    illegal_d = 1'b0;
                    count_d   = '0;
                end
            end
            S_LOAD:    state_d = S_IDLE;
            S_EN_ALL:  state_d = S_VFIND;
            S_VFIND:   state_d = S_VWAIT;
            S_VWAIT: begin
                first_d = 1'b0;
                // Only the opening victim search can reveal a capturable enemy king.
                if (first_q && bus.resp[7]) begin
                    illegal_d = 1'b1;
                    state_d   = S_DONE;
                end else if (bus.resp[6]) begin
                    state_d = S_DONE;
                end else begin
                    victim_d = bus.resp[5:0];
                    state_d  = S_AFIND;
                end
            end
            S_AFIND:   state_d = S_AWAIT;
            S_AWAIT: begin
                if (bus.resp[6]) begin
                    state_d = S_RECOLOR;
                end else begin
                    aggr_d  = bus.resp[5:0];
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.move_ready) begin
                    if (count_q != '1) count_d = count_q + COUNT_W'(1);
                    state_d = S_ADIS;
                end
            end
            S_ADIS:    state_d = S_AFIND;
            S_RECOLOR: state_d = S_VDIS;
            S_VDIS:    state_d = S_VFIND;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Command pins are registered from the next state; with no NOP available the
        // generator idles on a repeat of the most recent FIND command.
        cmd_addr_d = shadow_addr_q;
        cmd_data_d = shadow_data_q;
        unique case (state_d)
            S_LOAD: begin
                cmd_addr_d = {2'b00, bus.load_sq};
                cmd_data_d = {2'b00, bus.load_piece};
            end
            S_EN_ALL: begin
                cmd_addr_d = 8'h60;
                cmd_data_d = 6'd0;
            end
            S_VFIND: begin
                cmd_addr_d    = {3'b110, wtm_d, 4'b0000};
                cmd_data_d    = 6'd0;
                shadow_addr_d = cmd_addr_d;
                shadow_data_d = cmd_data_d;
            end
            S_AFIND: begin
                cmd_addr_d    = {3'b111, wtm_d, 4'b0000};
                cmd_data_d    = victim_d;
                shadow_addr_d = cmd_addr_d;
                shadow_data_d = cmd_data_d;
            end
            S_ADIS: begin
                cmd_addr_d = {2'b10, aggr_d};
                cmd_data_d = 6'd0;
            end
            S_RECOLOR: begin
                cmd_addr_d = {3'b010, wtm_d, 4'b0000};
                cmd_data_d = 6'd0;
            end
            S_VDIS: begin
                cmd_addr_d = {2'b10, victim_d};
                cmd_data_d = 6'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wtm_q         <= 1'b0;
            first_q       <= 1'b0;
            victim_q      <= 6'd0;
            aggr_q        <= 6'd0;
            illegal_q     <= 1'b0;
            count_q       <= '0;
            cmd_addr_q    <= 8'hC0;
            cmd_data_q    <= 6'd0;
            shadow_addr_q <= 8'hC0;
            shadow_data_q <= 6'd0;
        end else begin
            state_q       <= state_d;
            wtm_q         <= wtm_d;
            first_q       <= first_d;
            victim_q      <= victim_d;
            aggr_q        <= aggr_d;
            illegal_q     <= illegal_d;
            count_q       <= count_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_data_q    <= cmd_data_d;
            shadow_addr_q <= shadow_addr_d;
            shadow_data_q <= shadow_data_d;
        end
    end

    assign bus.load_ready = (state_q == S_IDLE);
    assign bus.cmd_addr   = cmd_addr_q;
    assign bus.cmd_data   = cmd_data_q;
    assign bus.move_valid = (state_q == S_EMIT);
    assign bus.move_from  = aggr_q;
    assign bus.move_to    = victim_q;
    assign busy           = (state_q != S_IDLE) && (state_q != S_LOAD);
    assign done           = (state_q == S_DONE);
    assign illegal_pos    = illegal_q;
    assign move_count     = count_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_chess_scan_seq.sv
// Bench for chess_scan_seq: a small move-generator model answers the command bus,
// and a scoreboard queue holds the moves each board is expected to produce.
module tb_chess_scan_seq;

    localparam int CW = 3;  // narrow counter so a 14-move board reaches saturation

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          start_wtm;
    logic          busy;
    logic          done;
    logic          illegal_pos;
    logic [CW-1:0] move_count;
    logic [3:0]    dbg_state;

    chess_scan_seq_if bus ();

    chess_scan_seq #(.COUNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .start      (start),
        .start_wtm  (start_wtm),
        .busy       (busy),
        .done       (done),
        .illegal_pos(illegal_pos),
        .move_count (move_count),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];

    // ---------------- generator model (knights are the only attackers) ----------------
    logic [3:0] board [64];
    logic       en    [64];
    logic [7:0] g_addr;
    logic [5:0] g_data;
    logic [7:0] resp_m;

    function automatic logic knight_hit(input int a, input int b);
        int dr;
        int df;
        dr = (a / 8) - (b / 8);
        df = (a % 8) - (b % 8);
        if (dr < 0) dr = -dr;
        if (df < 0) df = -df;
        return ((dr == 1) && (df == 2)) || ((dr == 2) && (df == 1));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                board[i] <= 4'hF;
                en[i]    <= 1'b1;
            end
            g_addr <= 8'hC0;
            g_data <= 6'd0;
        end else begin
            g_addr <= bus.cmd_addr;
            g_data <= bus.cmd_data;
            if (bus.cmd_addr[7:6] == 2'b00) begin
                board[bus.cmd_addr[5:0]] <= bus.cmd_data[3:0];
            end else if (bus.cmd_addr[7:6] == 2'b10) begin
                en[bus.cmd_addr[5:0]] <= bus.cmd_data[0];
            end else if (bus.cmd_addr == 8'h60) begin
                for (int i = 0; i < 64; i++) en[i] <= 1'b1;
            end else if (bus.cmd_addr[7:5] == 3'b010 && bus.cmd_addr[3:0] == 4'h0) begin
                for (int i = 0; i < 64; i++)
                    if (board[i] != 4'hF && board[i][3] == bus.cmd_addr[4]) en[i] <= 1'b1;
            end
        end
    end

    always_comb begin : gen_resp
        int   best_v;
        int   best_sq;
        int   pv;
        logic ill;
        logic side;
        logic hit;
        best_v  = -1;
        best_sq = 0;
        pv      = 0;
        ill     = 1'b0;
        hit     = 1'b0;
        side    = g_addr[4];
        if (g_addr[7:5] == 3'b110) begin
            // Victim search: most valuable attacked square, empty squares last, lowest index on ties.
            for (int v = 0; v < 64; v++) begin
                hit = 1'b0;
                for (int a = 0; a < 64; a++)
                    if (en[a] && board[a] == {side, 3'd1} && knight_hit(a, v)) hit = 1'b1;
                if (en[v] && hit && (board[v] == 4'hF || board[v][3] != side)) begin
                    pv = (board[v] == 4'hF) ? 0 : int'(board[v][2:0]) + 1;
                    if (board[v] != 4'hF && board[v][2:0] == 3'd5) ill = 1'b1;
                    if (pv > best_v) begin
                        best_v  = pv;
                        best_sq = v;
                    end
                end
            end
        end else if (g_addr[7:5] == 3'b111) begin
            for (int a = 0; a < 64; a++) begin
                if (en[a] && board[a] == {side, 3'd1} && knight_hit(a, int'(g_data))) begin
                    pv = int'(board[a][2:0]);
                    if (best_v < 0 || pv < best_v) begin
                        best_v  = pv;
                        best_sq = a;
                    end
                end
            end
        end
        resp_m = (best_v < 0) ? {ill, 1'b1, 6'd0} : {ill, 1'b0, best_sq[5:0]};
    end

    assign bus.resp = resp_m;

    // ---------------- checking and driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [5:0] from_sq, input logic [5:0] to_sq);
        exp_q.push_back({from_sq, to_sq});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic load(input logic [5:0] sq, input logic [3:0] piece);
        @(negedge clk);
        check("load_ready", 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_sq    = sq;
        bus.load_piece = piece;
        @(negedge clk);
        bus.load_valid = 1'b0;
        check("setpiece_addr", 32'(bus.cmd_addr), 32'({2'b00, sq}));
        check("setpiece_data", 32'(bus.cmd_data), 32'({2'b00, piece}));
    endtask

    task automatic start_scan(input logic wtm);
        @(negedge clk);
        start     = 1'b1;
        start_wtm = wtm;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: random ready
    task automatic drain(input int mode, input logic wtm);
        logic [11:0] e;
        logic        got_done;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            @(negedge clk);
            bus.move_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (bus.move_valid && bus.move_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_move", 32'({bus.move_from, bus.move_to}), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("move", 32'({bus.move_from, bus.move_to}), 32'(e));
                    check("emit_cmd", 32'(bus.cmd_addr), 32'({3'b111, wtm, 4'b0000}));
                end
            end
            if (done) got_done = 1'b1;
        end
        bus.move_ready = 1'b0;
        check("done_seen", 32'(got_done), 32'd1);
        check("moves_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        start_wtm      = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_sq    = 6'd0;
        bus.load_piece = 4'hF;
        bus.move_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_cmd_addr", 32'(bus.cmd_addr), 32'hC0);
        check("rst_cmd_data", 32'(bus.cmd_data), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_move_valid", 32'(bus.move_valid), 32'd0);
        check("rst_illegal", 32'(illegal_pos), 32'd0);
        check("rst_count", 32'(move_count), 32'd0);
        check("rst_load_ready", 32'(bus.load_ready), 32'd1);
        check("rst_from_to", 32'({bus.move_from, bus.move_to}), 32'd0);
        rst = 1'b0;

        // Empty board: EN_ALL, FIND-VICTIM, sample, done on the fourth cycle
        start_scan(1'b0);
        check("empty_en_all", 32'(bus.cmd_addr), 32'h60);
        check("empty_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("empty_vfind", 32'(bus.cmd_addr), 32'hC0);
        @(negedge clk);
        check("empty_vwait_cmd", 32'(bus.cmd_addr), 32'hC0);
        check("empty_not_done_yet", 32'(done), 32'd0);
        @(negedge clk);
        check("empty_done", 32'(done), 32'd1);
        check("empty_count", 32'(move_count), 32'd0);
        check("empty_illegal", 32'(illegal_pos), 32'd0);
        @(negedge clk);
        check("empty_done_pulse", 32'(done), 32'd0);
        check("empty_idle_busy", 32'(busy), 32'd0);

        // Lone white knight on b1
        load(6'd1, 4'h1);
        @(negedge clk);
        check("setpiece_revert", 32'(bus.cmd_addr), 32'hC0);
        push_exp(6'd1, 6'd11);
        push_exp(6'd1, 6'd16);
        push_exp(6'd1, 6'd18);
        start_scan(1'b0);
        drain(0, 1'b0);
        check("knight_count", 32'(move_count), 32'd3);
        check("knight_illegal", 32'(illegal_pos), 32'd0);

        // Valuable victims first: queen, then pawn, then the empty square
        do_reset();
        load(6'd1, 4'h1);
        load(6'd18, 4'hC);
        load(6'd16, 4'h8);
        push_exp(6'd1, 6'd18);
        push_exp(6'd1, 6'd16);
        push_exp(6'd1, 6'd11);
        start_scan(1'b0);
        drain(1, 1'b0);
        check("mvv_count", 32'(move_count), 32'd3);

        // Enemy king en prise: illegal position, no moves
        do_reset();
        load(6'd1, 4'h1);
        load(6'd18, 4'hD);
        start_scan(1'b0);
        drain(0, 1'b0);
        check("illegal_flag", 32'(illegal_pos), 32'd1);
        check("illegal_count", 32'(move_count), 32'd0);

        // Consumer stall on the first move; start during busy must be ignored
        do_reset();
        load(6'd1, 4'h1);
        push_exp(6'd1, 6'd11);
        push_exp(6'd1, 6'd16);
        push_exp(6'd1, 6'd18);
        start_scan(1'b0);
        begin
            logic seen;
            seen = 1'b0;
            for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
                @(negedge clk);
                if (bus.move_valid) seen = 1'b1;
            end
            check("stall_valid_seen", 32'(seen), 32'd1);
        end
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                start     = 1'b1;
                start_wtm = 1'b1;
            end else begin
                start = 1'b0;
            end
            check("stall_valid", 32'(bus.move_valid), 32'd1);
            check("stall_pair", 32'({bus.move_from, bus.move_to}), 32'({6'd1, 6'd11}));
            check("stall_cmd", 32'(bus.cmd_addr), 32'hE0);
            @(negedge clk);
        end
        start = 1'b0;
        check("stall_count", 32'(move_count), 32'd0);
        check("stall_load_ready", 32'(bus.load_ready), 32'd0);
        drain(0, 1'b0);
        check("stall_final_count", 32'(move_count), 32'd3);

        // Reset in the middle of a scan, then reload and rescan
        do_reset();
        load(6'd1, 4'h1);
        start_scan(1'b0);
        begin
            logic hit;
            hit = 1'b0;
            for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
                if (dbg_state == 4'd6) hit = 1'b1;
                else @(negedge clk);
            end
            check("await_reached", 32'(hit), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cmd", 32'(bus.cmd_addr), 32'hC0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(bus.move_valid), 32'd0);
        check("midrst_count", 32'(move_count), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        load(6'd1, 4'h1);
        push_exp(6'd1, 6'd11);
        push_exp(6'd1, 6'd16);
        push_exp(6'd1, 6'd18);
        start_scan(1'b0);
        drain(1, 1'b0);
        check("rescan_count", 32'(move_count), 32'd3);

        // Black to move: knight on g8
        do_reset();
        load(6'd62, 4'h9);
        push_exp(6'd62, 6'd45);
        push_exp(6'd62, 6'd47);
        push_exp(6'd62, 6'd52);
        start_scan(1'b1);
        drain(0, 1'b1);
        check("black_count", 32'(move_count), 32'd3);

        // Three knights, 14 moves, shared victims take the lower aggressor first
        do_reset();
        load(6'd1, 4'h1);
        load(6'd6, 4'h1);
        load(6'd27, 4'h1);
        push_exp(6'd27, 6'd10);
        push_exp(6'd1,  6'd11);
        push_exp(6'd6,  6'd12);
        push_exp(6'd27, 6'd12);
        push_exp(6'd1,  6'd16);
        push_exp(6'd27, 6'd17);
        push_exp(6'd1,  6'd18);
        push_exp(6'd6,  6'd21);
        push_exp(6'd27, 6'd21);
        push_exp(6'd6,  6'd23);
        push_exp(6'd27, 6'd33);
        push_exp(6'd27, 6'd37);
        push_exp(6'd27, 6'd42);
        push_exp(6'd27, 6'd44);
        start_scan(1'b0);
        drain(1, 1'b0);
        check("sat_count", 32'(move_count), 32'((1 << CW) - 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
